// File: rtl/slow_clock_monitor.sv
// slow_clock_monitor: resynchronises a divided slow_clock level into the fast domain,
// emits a one-cycle tick per rising edge, measures the rising-to-rising period and
// tracks lock / loss of the slow clock.
// Optional feature: define SLOW_CLK_DUTY_EN to add the high_time_o duty measurement.
module slow_clock_monitor #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned EXPECTED_PERIOD = 125000,
  parameter int unsigned TOLERANCE       = 1024,
  parameter int unsigned TIMEOUT         = 262143
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             slow_clock_i,
  output logic             tick_o,
  output logic [CNT_W-1:0] period_o,
  output logic             period_valid_o,
  output logic             locked_o,
  output logic             clock_lost_o
`ifdef SLOW_CLK_DUTY_EN
  ,
  output logic [CNT_W-1:0] high_time_o
`endif
);

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TimeoutM1  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0]   ExpVal     = (CNT_W+1)'(EXPECTED_PERIOD);
  localparam logic [CNT_W:0]   TolVal     = (CNT_W+1)'(TOLERANCE);

  typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   level_q;
  logic                   tick_q, tick_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic                   pv_q, pv_d;
  logic                   lost_q, lost_d;
  state_e                 state_q, state_d;
  logic                   timeout_hit;
  logic [CNT_W:0]         cnt_ext, diff;
  logic                   in_tol;

  // Synchroniser shift and registered rising-edge detect on the synchronised level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], slow_clock_i};
    tick_d = sync_q[SYNC_STAGES-1] & ~level_q;
  end

  // Period counter restarts on tick and saturates at TIMEOUT so it never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (tick_q) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q < TimeoutVal) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Tolerance window check on the finished period; a tick on the last cycle beats loss.
  always_comb begin
    cnt_ext     = {1'b0, cnt_q};
    diff        = (cnt_ext >= ExpVal) ? (cnt_ext - ExpVal) : (ExpVal - cnt_ext);
    in_tol      = (diff <= TolVal);
    timeout_hit = ~tick_q & (cnt_q >= TimeoutM1);
  end

  // FSM next-state plus period / valid / loss updates.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    pv_d     = 1'b0;
    lost_d   = lost_q;
    if (tick_q) begin
      lost_d = 1'b0;
      case (state_q)
        StSearch: state_d = StMeasure;
        StMeasure, StLocked: begin
          period_d = cnt_q;
          pv_d     = 1'b1;
          state_d  = in_tol ? StLocked : StMeasure;
        end
        default: state_d = StSearch;
      endcase
    end else if (timeout_hit) begin
      state_d = StSearch;
      lost_d  = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync_q   <= '0;
      level_q  <= 1'b0;
      tick_q   <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      lost_q   <= 1'b0;
      state_q  <= StSearch;
    end else begin
      sync_q   <= sync_d;
      level_q  <= sync_q[SYNC_STAGES-1];
      tick_q   <= tick_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      lost_q   <= lost_d;
      state_q  <= state_d;
    end
  end

`ifdef SLOW_CLK_DUTY_EN
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;

  // High-cycle counter: the tick cycle itself is high, so restart at one.
  always_comb begin
    high_cnt_d  = high_cnt_q;
    high_time_d = high_time_q;
    if (tick_q) begin
      high_cnt_d = CNT_W'(1);
    end else if (level_q && (high_cnt_q < TimeoutVal)) begin
      high_cnt_d = high_cnt_q + CNT_W'(1);
    end
    if (pv_d) begin
      high_time_d = high_cnt_q;
    end
  end

  // Duty registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      high_cnt_q  <= '0;
      high_time_q <= '0;
    end else begin
      high_cnt_q  <= high_cnt_d;
      high_time_q <= high_time_d;
    end
  end

  assign high_time_o = high_time_q;
`endif

  assign tick_o         = tick_q;
  assign period_o       = period_q;
  assign period_valid_o = pv_q;
  assign locked_o       = (state_q == StLocked);
  assign clock_lost_o   = lost_q;

endmodule
